move_controller: RTL and testbench

- Upstream stage of the tic-tac-toe win checker.
- Turns debounced player button levels into board writes: tracks whose turn it is and rejects illegal moves.
- Drives the 18-bit packed board vector and the one-cycle undo pulse that the win checker consumes.
- Keeps a move-history stack so the last move can be retracted.

---
 rtl/ttt_pkg.sv | 48 ++++
 rtl/move_controller_rise_edge.sv | 25 ++
 rtl/move_controller.sv | 171 +++++++++++++++++
 tb/tb_move_controller.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ttt_pkg.sv
// Shared tic-tac-toe definitions: tile encodings, board geometry, FSM state
// type and small helpers for reading/writing one tile of the packed board.
package ttt_pkg;

  localparam logic [1:0] TILE_EMPTY = 2'b00;
  localparam logic [1:0] TILE_X     = 2'b01;
  localparam logic [1:0] TILE_O     = 2'b10;

  localparam int unsigned NUM_TILES = 9;
  localparam int unsigned TILE_W    = 2;
  localparam int unsigned BOARD_W   = 18;
  localparam int unsigned IDX_W     = 4;
  localparam int unsigned CNT_W     = 4;

  typedef enum logic {
    PLAY   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  // Read tile idx; out-of-range indices read as empty.
  function automatic logic [TILE_W-1:0] tile_at(input logic [BOARD_W-1:0] board,
                                                input logic [IDX_W-1:0]   idx);
    logic [TILE_W-1:0] t;
    t = TILE_EMPTY;
    for (int unsigned k = 0; k < NUM_TILES; k++) begin
      if (idx == IDX_W'(k)) t = board[k*TILE_W +: TILE_W];
    end
    return t;
  endfunction

  // Return board with tile idx replaced by mark; out-of-range idx leaves it unchanged.
  function automatic logic [BOARD_W-1:0] set_tile(input logic [BOARD_W-1:0] board,
                                                  input logic [IDX_W-1:0]   idx,
                                                  input logic [TILE_W-1:0]  mark);
    logic [BOARD_W-1:0] b;
    b = board;
    for (int unsigned k = 0; k < NUM_TILES; k++) begin
      if (idx == IDX_W'(k)) b[k*TILE_W +: TILE_W] = mark;
    end
    return b;
  endfunction

  // Swap between the two player marks.
  function automatic logic [TILE_W-1:0] other_mark(input logic [TILE_W-1:0] mark);
    return (mark == TILE_X) ? TILE_O : TILE_X;
  endfunction

endpackage

// File: rtl/move_controller_rise_edge.sv
// rise_edge: one-bit registered rising-edge detector.
// Ports:
//   clk      - system clock
//   reset    - synchronous active-high reset; masks the edge output
//   i_level  - debounced input level
//   o_edge_c - combinational pulse, high the first cycle i_level is high
// The level register keeps sampling during reset so a button held through
// reset does not produce an edge when reset drops.
module rise_edge (
  input  logic clk,
  input  logic reset,
  input  logic i_level,
  output logic o_edge_c
);

  logic r_level_q;

  // Previous-cycle level
  always_ff @(posedge clk) begin
    r_level_q <= i_level;
  end

  assign o_edge_c = i_level & ~r_level_q & ~reset;

endmodule

// File: rtl/move_controller.sv
// move_controller: turns debounced button levels into tic-tac-toe board
// writes, tracks the player turn, rejects illegal moves and, when built with
// MOVE_UNDO_EN defined, keeps a move-history stack so moves can be retracted.
// Without MOVE_UNDO_EN there is no stack, btn_undo is ignored, undo_sig stays
// 0 and LOCKED is terminal until reset.
// Ports:
//   clk, reset    - clock, synchronous active-high reset
//   btn_place     - level; rising edge requests a move at sel_idx
//   sel_idx       - target tile 0..8 (row-major)
//   btn_undo      - level; rising edge requests undo of the last move
//   game_over     - win indication from the downstream checker
//   tiles         - packed board, tile k at [2k+1:2k]
//   undo_sig      - one-cycle pulse per performed undo
//   turn          - mark the next accepted move will place
//   move_count    - occupied tiles 0..9
//   move_accept   - one-cycle pulse per written move
//   illegal_move  - one-cycle pulse per rejected place request
//   board_full    - high while move_count == 9
module move_controller
  import ttt_pkg::*;
#(
  parameter logic [1:0]  FIRST_PLAYER = 2'b01,
  parameter int unsigned HIST_DEPTH   = 9
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               btn_place,
  input  logic [IDX_W-1:0]   sel_idx,
  input  logic               btn_undo,
  input  logic               game_over,
  output logic [BOARD_W-1:0] tiles,
  output logic               undo_sig,
  output logic [1:0]         turn,
  output logic [CNT_W-1:0]   move_count,
  output logic               move_accept,
  output logic               illegal_move,
  output logic               board_full
);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [BOARD_W-1:0]   w_tiles_nxt;
  logic [1:0]           w_turn_nxt;
  logic [CNT_W-1:0]     w_count_nxt;
  logic                 w_accept_nxt;
  logic                 w_illegal_nxt;
  logic                 w_undo_nxt;

  logic                 w_place_edge;
  logic                 w_undo_edge;
  logic                 w_undo_go;
  logic                 w_stack_full;
  logic [IDX_W-1:0]     w_pop_idx;
  logic                 w_place_ok;
  logic                 w_place_go;
  logic                 w_place_bad;

  rise_edge u_place_edge (
    .clk      (clk),
    .reset    (reset),
    .i_level  (btn_place),
    .o_edge_c (w_place_edge)
  );

`ifdef MOVE_UNDO_EN
  localparam int unsigned SP_W = $clog2(HIST_DEPTH + 1);

  logic [SP_W-1:0]  r_sp;
  logic [IDX_W-1:0] r_hist [HIST_DEPTH];

  rise_edge u_undo_edge (
    .clk      (clk),
    .reset    (reset),
    .i_level  (btn_undo),
    .o_edge_c (w_undo_edge)
  );

  assign w_stack_full = (r_sp >= SP_W'(HIST_DEPTH));
  assign w_undo_go    = w_undo_edge && (move_count != '0);
  assign w_pop_idx    = r_hist[r_sp - SP_W'(1)];

  // History stack: push on accepted move, pop on performed undo
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sp <= '0;
    end else if (w_undo_go) begin
      r_sp <= r_sp - SP_W'(1);
    end else if (w_place_go) begin
      r_hist[r_sp] <= sel_idx;
      r_sp         <= r_sp + SP_W'(1);
    end
  end
`else
  logic w_unused_undo;
  localparam int unsigned unused_hist_depth = HIST_DEPTH;

  assign w_unused_undo = btn_undo;
  assign w_undo_edge   = 1'b0;
  assign w_undo_go     = 1'b0;
  assign w_stack_full  = 1'b0;
  assign w_pop_idx     = '0;
`endif

  // A place request is dropped silently whenever an undo edge arrives with it
  assign w_place_ok  = (r_state == PLAY) &&
                       (sel_idx <= IDX_W'(NUM_TILES - 1)) &&
                       (tile_at(tiles, sel_idx) == TILE_EMPTY) &&
                       !w_stack_full;
  assign w_place_go  = w_place_edge && !w_undo_edge && w_place_ok;
  assign w_place_bad = w_place_edge && !w_undo_edge && !w_place_ok;

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt   = r_state;
    w_tiles_nxt   = tiles;
    w_turn_nxt    = turn;
    w_count_nxt   = move_count;
    w_accept_nxt  = 1'b0;
    w_illegal_nxt = 1'b0;
    w_undo_nxt    = 1'b0;

    if (w_undo_go) begin
      w_tiles_nxt = set_tile(tiles, w_pop_idx, TILE_EMPTY);
      w_turn_nxt  = other_mark(turn);
      w_count_nxt = move_count - CNT_W'(1);
      w_undo_nxt  = 1'b1;
      // game_over is re-sampled next cycle and may lock again
      w_state_nxt = PLAY;
    end else begin
      if (w_place_go) begin
        w_tiles_nxt  = set_tile(tiles, sel_idx, turn);
        w_turn_nxt   = other_mark(turn);
        w_count_nxt  = move_count + CNT_W'(1);
        w_accept_nxt = 1'b1;
      end
      w_illegal_nxt = w_place_bad;
      if ((r_state == PLAY) &&
          (game_over || (w_count_nxt == CNT_W'(NUM_TILES)))) begin
        w_state_nxt = LOCKED;
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= PLAY;
    else       r_state <= w_state_nxt;
  end

  // Registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      tiles        <= '0;
      turn         <= FIRST_PLAYER;
      move_count   <= '0;
      move_accept  <= 1'b0;
      illegal_move <= 1'b0;
      undo_sig     <= 1'b0;
      board_full   <= 1'b0;
    end else begin
      tiles        <= w_tiles_nxt;
      turn         <= w_turn_nxt;
      move_count   <= w_count_nxt;
      move_accept  <= w_accept_nxt;
      illegal_move <= w_illegal_nxt;
      undo_sig     <= w_undo_nxt;
      board_full   <= (w_count_nxt == CNT_W'(NUM_TILES));
    end
  end

endmodule

// File: tb/tb_move_controller.sv
// Scoreboard bench for move_controller: a game-level reference model predicts
// each pulse event and the board state after it; a negedge monitor compares
// whatever the DUT presents. Works with or without MOVE_UNDO_EN.
module tb_move_controller;
  import ttt_pkg::*;

  localparam int HD = 9;
`ifdef MOVE_UNDO_EN
  localparam bit UNDO_EN = 1'b1;
`else
  localparam bit UNDO_EN = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        btn_place;
  logic [3:0]  sel_idx;
  logic        btn_undo;
  logic        game_over;
  logic [17:0] tiles;
  logic        undo_sig;
  logic [1:0]  turn;
  logic [3:0]  move_count;
  logic        move_accept;
  logic        illegal_move;
  logic        board_full;

  move_controller #(.FIRST_PLAYER(2'b01), .HIST_DEPTH(9)) dut (
    .clk          (clk),
    .reset        (reset),
    .btn_place    (btn_place),
    .sel_idx      (sel_idx),
    .btn_undo     (btn_undo),
    .game_over    (game_over),
    .tiles        (tiles),
    .undo_sig     (undo_sig),
    .turn         (turn),
    .move_count   (move_count),
    .move_accept  (move_accept),
    .illegal_move (illegal_move),
    .board_full   (board_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  kind;   // {undo, illegal, accept}
    logic [17:0] tiles;
    logic [1:0]  turn;
    logic [3:0]  count;
    logic        full;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference game state
  int m_board[9];
  int m_turn;
  int m_hist[$];
  bit m_locked;
  bit m_prev_p, m_prev_u;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [17:0] m_tiles();
    logic [17:0] t;
    t = '0;
    for (int k = 0; k < 9; k++) t[2*k +: 2] = 2'(m_board[k]);
    return t;
  endfunction

  function automatic void push_exp(input logic [2:0] kind);
    exp_t x;
    x.kind  = kind;
    x.tiles = m_tiles();
    x.turn  = 2'(m_turn);
    x.count = 4'(m_hist.size());
    x.full  = (m_hist.size() == 9);
    exp_q.push_back(x);
  endfunction

  // Predict the effect of the upcoming clock edge given the driven inputs
  task automatic model(input bit bp, input int sel, input bit bu, input bit go, input bit rst);
    bit pe, ue, was_locked, undone;
    int idx;
    if (rst) begin
      for (int k = 0; k < 9; k++) m_board[k] = 0;
      m_turn = 1;
      m_hist.delete();
      m_locked = 1'b0;
      m_prev_p = bp;
      m_prev_u = bu;
      return;
    end
    pe = bp && !m_prev_p;
    ue = bu && !m_prev_u && UNDO_EN;
    m_prev_p = bp;
    m_prev_u = bu;
    was_locked = m_locked;
    undone = 1'b0;
    if (ue) begin
      if (m_hist.size() > 0) begin
        idx = m_hist.pop_back();
        m_board[idx] = 0;
        m_turn = 3 - m_turn;
        undone = 1'b1;
        push_exp(3'b100);
      end
    end else if (pe) begin
      if (!was_locked && sel < 9 && m_board[sel] == 0 && m_hist.size() < HD) begin
        m_board[sel] = m_turn;
        m_hist.push_back(sel);
        m_turn = 3 - m_turn;
        push_exp(3'b001);
      end else begin
        push_exp(3'b010);
      end
    end
    if (undone) m_locked = 1'b0;
    else if (!was_locked && (go || m_hist.size() == 9)) m_locked = 1'b1;
  endtask

  task automatic step(input bit bp, input logic [3:0] sel, input bit bu, input bit go, input bit rst);
    btn_place = bp;
    sel_idx   = sel;
    btn_undo  = bu;
    game_over = go;
    reset     = rst;
    model(bp, int'(sel), bu, go, rst);
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] sel, input bit go);
    step(1'b1, sel, 1'b0, go, 1'b0);
    step(1'b0, sel, 1'b0, go, 1'b0);
  endtask

  task automatic check_state(input string tag);
    check({tag, "_tiles"}, tiles, m_tiles());
    check({tag, "_turn"},  turn, 32'(m_turn));
    check({tag, "_count"}, move_count, 32'(m_hist.size()));
    check({tag, "_full"},  board_full, (m_hist.size() == 9));
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_tiles"},   tiles, 0);
    check({tag, "_turn"},    turn, 32'h1);
    check({tag, "_count"},   move_count, 0);
    check({tag, "_accept"},  move_accept, 0);
    check({tag, "_illegal"}, illegal_move, 0);
    check({tag, "_undo"},    undo_sig, 0);
    check({tag, "_full"},    board_full, 0);
  endtask

  // Monitor: every pulse must match the oldest predicted event
  always @(negedge clk) begin
    if (move_accept || illegal_move || undo_sig) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_pulse: got %b expected none at %0t",
                 {undo_sig, illegal_move, move_accept}, $time);
      end else begin
        mon_e = exp_q.pop_front();
        check("pulse_kind",  {undo_sig, illegal_move, move_accept}, mon_e.kind);
        check("pulse_tiles", tiles, mon_e.tiles);
        check("pulse_turn",  turn, mon_e.turn);
        check("pulse_count", move_count, mon_e.count);
        check("pulse_full",  board_full, mon_e.full);
      end
    end
  end

  initial begin
    logic bp, bu, go, rst;
    logic [3:0] sel;
    int fill_order[9] = '{0, 1, 2, 4, 3, 5, 7, 6, 8};

    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    check_reset("reset");

    // First move in the centre
    press(4, 0);
    check("centre_tiles", tiles, 32'h00100);
    check("centre_turn", turn, 32'h2);
    check("centre_count", move_count, 1);

    // Occupied tile and out-of-range index
    press(4, 0);
    press(11, 0);
    check("illegal_tiles", tiles, 32'h00100);
    check("illegal_count", move_count, 1);

    // X takes row 1, then game_over locks the board
    step(0, 0, 0, 0, 1);
    press(0, 0); press(3, 0); press(1, 0); press(4, 0); press(2, 0);
    step(0, 8, 0, 1, 0);
    press(8, 1);
    check("locked_tile8", tiles[17:16], 0);
    check_state("locked");

    // Undo while locked (game_over dropped in the same cycle), then place at 8
    step(0, 8, 1, 0, 0);
    step(0, 8, 0, 0, 0);
`ifdef MOVE_UNDO_EN
    check("undo_tile2", tiles[5:4], 0);
    check("undo_count", move_count, 4);
    check("undo_turn", turn, 32'h1);
`else
    check("noundo_tile2", tiles[5:4], 32'h1);
    check("noundo_count", move_count, 5);
`endif
    press(8, 0);
    check_state("after_undo");

    // Simultaneous place and undo edges with two moves made
    step(0, 0, 0, 0, 1);
    press(0, 0); press(1, 0);
    step(1, 5, 1, 0, 0);
    step(0, 5, 0, 0, 0);
    check_state("simul");

    // Held place button gives one move
    for (int i = 0; i < 10; i++) step(1, 6, 0, 0, 0);
    step(0, 6, 0, 0, 0);
    check_state("held");

    // Fill the board without a win
    step(0, 0, 0, 0, 1);
    for (int i = 0; i < 9; i++) press(4'(fill_order[i]), 0);
    check("full_flag", board_full, 1);
    press(0, 0);
    check_state("full");

    // Reset during a place edge; button held across reset gives no edge
    step(1, 3, 0, 0, 1);
    check_reset("mid_reset");
    step(1, 3, 0, 0, 0);
    step(0, 3, 0, 0, 0);
    check_state("post_reset");

    // Randomized games
    for (int g = 0; g < 8; g++) begin
      step(0, 0, 0, 0, 1);
      for (int c = 0; c < 120; c++) begin
        bp  = ($urandom_range(0, 2) == 0);
        bu  = ($urandom_range(0, 5) == 0);
        go  = ($urandom_range(0, 24) == 0);
        rst = ($urandom_range(0, 150) == 0);
        sel = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(9, 15))
                                          : 4'($urandom_range(0, 8));
        step(bp, sel, bu, go, rst);
        if (c % 10 == 9) check_state("rand");
      end
    end

    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    check("queue_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
